// File: rtl/aes128_pkg.sv
// ============================================================================
// Module   : aes128_pkg
// Brief    : Shared constants and types for the AES-128 share arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package aes128_pkg;
    localparam int AES_BLK_W       = 128;
    localparam int DEFAULT_LATENCY = 10;

    typedef logic req_id_t;
endpackage

`default_nettype wire

// File: rtl/aes128_resp_fifo.sv
// ============================================================================
// Module   : aes128_resp_fifo
// Brief    : First-word fall-through response FIFO, 128-bit, power-of-2 depth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_resp_fifo
    import aes128_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en_i,
    input  logic [AES_BLK_W-1:0] wr_data_i,
    input  logic                 rd_ready_i,
    output logic                 rd_valid_o,
    output logic [AES_BLK_W-1:0] rd_data_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AES_BLK_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wptr_q;
    logic [AW-1:0]        rptr_q;
    logic [AW:0]          count_q;
    logic [AW:0]          count_d;
    logic                 rd_fire_w;

    assign rd_valid_o = (count_q != '0);
    assign rd_fire_w  = rd_valid_o && rd_ready_i;
    // Head reads as zero when empty so the data port has a defined reset value.
    assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;

    always_comb begin
        count_d = count_q;
        case ({wr_en_i, rd_fire_w})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (wr_en_i) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_fire_w) begin
                rptr_q <= rptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end
endmodule

`default_nettype wire

// File: rtl/aes128_share_arbiter.sv
// ============================================================================
// Module   : aes128_share_arbiter
// Brief    : Credit-based round-robin sharing of one pipelined AES-128 core
//            between two requesters, with per-requester response FIFOs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aes128_share_arbiter
    import aes128_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int RESP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AES_BLK_W-1:0] req0_data,
    input  logic [AES_BLK_W-1:0] req0_key,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AES_BLK_W-1:0] req1_data,
    input  logic [AES_BLK_W-1:0] req1_key,
    output logic                 rsp0_valid,
    input  logic                 rsp0_ready,
    output logic [AES_BLK_W-1:0] rsp0_data,
    output logic                 rsp1_valid,
    input  logic                 rsp1_ready,
    output logic [AES_BLK_W-1:0] rsp1_data,
    output logic                 core_start,
    output logic [AES_BLK_W-1:0] core_data,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0] core_out,
    input  logic                 core_done
);
    localparam int TAG_DEPTH = LATENCY + 1;
    localparam int TAG_AW    = $clog2(TAG_DEPTH);
    localparam int TAG_CW    = $clog2(TAG_DEPTH + 1);
    localparam int CW        = $clog2(RESP_DEPTH + 1);

    logic [1:0]           valid_w;
    logic [1:0]           elig_w;
    logic [1:0]           grant_w;
    logic [1:0]           rsp_ready_w;
    logic [1:0]           rsp_pop_w;
    logic [1:0]           fifo_wr_w;
    logic [1:0]           fifo_valid_w;
    logic [AES_BLK_W-1:0] fifo_data_w [2];

    logic [CW-1:0]        credit_q [2];
    logic [CW-1:0]        credit_d [2];
    req_id_t              last_grant_q;
    logic                 ready_en_q;
    logic                 core_start_q;
    logic [AES_BLK_W-1:0] core_data_q;
    logic [AES_BLK_W-1:0] core_key_q;
    logic                 err_orphan_q;

    req_id_t              tag_mem_q [TAG_DEPTH];
    logic [TAG_AW-1:0]    tag_wptr_q;
    logic [TAG_AW-1:0]    tag_rptr_q;
    logic [TAG_CW-1:0]    tag_cnt_q;
    logic                 tag_push_w;
    logic                 tag_pop_w;
    req_id_t              tag_head_w;

    function automatic logic [TAG_AW-1:0] tag_inc(input logic [TAG_AW-1:0] p);
        return (p == TAG_AW'(TAG_DEPTH - 1)) ? '0 : p + TAG_AW'(1);
    endfunction

    assign valid_w     = {req1_valid, req0_valid};
    assign rsp_ready_w = {rsp1_ready, rsp0_ready};
    assign rsp_pop_w   = fifo_valid_w & rsp_ready_w;

    always_comb begin
        elig_w  = '0;
        grant_w = '0;
        for (int i = 0; i < 2; i++) begin
            elig_w[i] = ready_en_q && !reset && valid_w[i] && (credit_q[i] != '0);
        end
        // On a tie the requester not granted last time wins.
        if (elig_w == 2'b11) begin
            grant_w = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant_w = elig_w;
        end
    end

    assign req0_ready = grant_w[0];
    assign req1_ready = grant_w[1];

    assign tag_push_w = |grant_w;
    assign tag_pop_w  = core_done && (tag_cnt_q != '0);
    assign tag_head_w = tag_mem_q[tag_rptr_q];
    assign fifo_wr_w  = {tag_pop_w && tag_head_w, tag_pop_w && !tag_head_w};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            credit_d[i] = credit_q[i];
            case ({grant_w[i], rsp_pop_w[i]})
                2'b10:   credit_d[i] = credit_q[i] - 1'b1;
                2'b01:   credit_d[i] = credit_q[i] + 1'b1;
                default: credit_d[i] = credit_q[i];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= CW'(RESP_DEPTH);
            end
            last_grant_q <= 1'b1;
            ready_en_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            err_orphan_q <= 1'b0;
            tag_wptr_q   <= '0;
            tag_rptr_q   <= '0;
            tag_cnt_q    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                credit_q[i] <= credit_d[i];
            end
            ready_en_q   <= 1'b1;
            core_start_q <= tag_push_w;
            if (tag_push_w) begin
                last_grant_q <= grant_w[1];
                core_data_q  <= grant_w[1] ? req1_data : req0_data;
                core_key_q   <= grant_w[1] ? req1_key  : req0_key;
                tag_wptr_q   <= tag_inc(tag_wptr_q);
            end
            if (tag_pop_w) begin
                tag_rptr_q <= tag_inc(tag_rptr_q);
            end
            // A completion with nothing outstanding is dropped and flagged.
            if (core_done && (tag_cnt_q == '0)) begin
                err_orphan_q <= 1'b1;
            end
            case ({tag_push_w, tag_pop_w})
                2'b10:   tag_cnt_q <= tag_cnt_q + 1'b1;
                2'b01:   tag_cnt_q <= tag_cnt_q - 1'b1;
                default: tag_cnt_q <= tag_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (tag_push_w) begin
            tag_mem_q[tag_wptr_q] <= grant_w[1];
        end
    end

    assign core_start = core_start_q;
    assign core_data  = core_data_q;
    assign core_key   = core_key_q;

    for (genvar g = 0; g < 2; g++) begin : g_rsp
        aes128_resp_fifo #(
            .DEPTH (RESP_DEPTH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .wr_en_i    (fifo_wr_w[g]),
            .wr_data_i  (core_out),
            .rd_ready_i (rsp_ready_w[g]),
            .rd_valid_o (fifo_valid_w[g]),
            .rd_data_o  (fifo_data_w[g])
        );
    end

    assign rsp0_valid = fifo_valid_w[0];
    assign rsp1_valid = fifo_valid_w[1];
    assign rsp0_data  = fifo_data_w[0];
    assign rsp1_data  = fifo_data_w[1];
endmodule

`default_nettype wire

// File: tb/tb_aes128_share_arbiter.sv
// ============================================================================
// Module   : tb_aes128_share_arbiter
// Brief    : Scoreboard bench with a delay-line core model for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aes128_share_arbiter;
    localparam int LAT   = 10;
    localparam int DEPTH = 4;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_data = '0, req0_key = '0, req1_data = '0, req1_key = '0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [127:0] rsp0_data, rsp1_data;
    logic         core_start, core_done;
    logic [127:0] core_data, core_key, core_out;

    logic         inj = 1'b0;
    logic [127:0] inj_data = '0;
    logic         pv [LAT];
    logic [127:0] pd [LAT];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] exp_q [2][$];
    logic [255:0] issue_q [$];
    int           win_log [$];
    int           cs_log [$];
    int           outst [2];
    int           grants [2];
    int           pops [2];
    int           last_win;
    bit           rst_prev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes128_share_arbiter #(
        .LATENCY    (LAT),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_data  (req0_data),
        .req0_key   (req0_key),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_data  (req1_data),
        .req1_key   (req1_key),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .core_start (core_start),
        .core_data  (core_data),
        .core_key   (core_key),
        .core_out   (core_out),
        .core_done  (core_done)
    );

    // Stand-in cipher: the known test vector maps to its real ciphertext.
    function automatic logic [127:0] core_fn(input logic [127:0] d, input logic [127:0] k);
        if (d == C_PT && k == C_KEY) return C_CT;
        return d ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < LAT; i++) begin
            if (reset) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end else if (i == 0) begin
                pv[0] <= core_start;
                pd[0] <= core_fn(core_data, core_key);
            end else begin
                pv[i] <= pv[i-1];
                pd[i] <= pd[i-1];
            end
        end
    end

    assign core_done = pv[LAT-1] | inj;
    assign core_out  = inj ? inj_data : pd[LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor and reference model: all sampling mid-cycle.
    always @(negedge clk) begin
        logic [1:0]   rv, rr, vv, rdy, exp_rdy;
        logic [127:0] rd [2];
        logic [127:0] qd [2];
        logic [127:0] qk [2];
        logic [127:0] e;
        logic [255:0] iss;
        if (reset) begin
            for (int n = 0; n < 2; n++) begin
                exp_q[n].delete();
                outst[n] = 0;
            end
            issue_q.delete();
            win_log.delete();
            cs_log.delete();
            last_win = 1;
            rst_prev = 1'b1;
        end else begin
            rv = {rsp1_valid, rsp0_valid};
            rr = {rsp1_ready, rsp0_ready};
            vv = {req1_valid, req0_valid};
            rdy = {req1_ready, req0_ready};
            rd[0] = rsp0_data; rd[1] = rsp1_data;
            qd[0] = req0_data; qd[1] = req1_data;
            qk[0] = req0_key;  qk[1] = req1_key;
            exp_rdy = '0;
            if (!rst_prev) begin
                for (int n = 0; n < 2; n++) exp_rdy[n] = vv[n] && (outst[n] < DEPTH);
                if (exp_rdy == 2'b11) exp_rdy = (last_win == 1) ? 2'b01 : 2'b10;
            end
            chk("req_ready", {126'd0, rdy}, {126'd0, exp_rdy});
            rst_prev = 1'b0;
            for (int n = 0; n < 2; n++) begin
                if (vv[n] && rdy[n]) begin
                    exp_q[n].push_back(core_fn(qd[n], qk[n]));
                    issue_q.push_back({qd[n], qk[n]});
                    outst[n]++;
                    grants[n]++;
                    last_win = n;
                    win_log.push_back(n);
                end
            end
            if (core_start) begin
                cs_log.push_back(cyc);
                if (issue_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL core_start: got unexpected issue, required none");
                end else begin
                    iss = issue_q.pop_front();
                    chk("core_data", core_data, iss[255:128]);
                    chk("core_key", core_key, iss[127:0]);
                end
            end
            for (int n = 0; n < 2; n++) begin
                if (rv[n] && exp_q[n].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp%0d_valid: got 1 with no response pending, required 0", n);
                end else if (rv[n] && rr[n]) begin
                    e = exp_q[n].pop_front();
                    chk($sformatf("rsp%0d_data", n), rd[n], e);
                    outst[n]--;
                    pops[n]++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rand_data();
        req0_data = rnd128(); req0_key = rnd128();
        req1_data = rnd128(); req1_key = rnd128();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_core_start"}, {127'd0, core_start}, '0);
        chk({tag, "_core_data"}, core_data, '0);
        chk({tag, "_core_key"}, core_key, '0);
        chk({tag, "_rsp_valid"}, {126'd0, rsp1_valid, rsp0_valid}, '0);
        chk({tag, "_rsp0_data"}, rsp0_data, '0);
        chk({tag, "_rsp1_data"}, rsp1_data, '0);
        chk({tag, "_req_ready"}, {126'd0, req1_ready, req0_ready}, '0);
        chk({tag, "_err_orphan"}, {127'd0, dut.err_orphan_q}, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (5) step();
        reset = 1'b0;
    endtask

    task automatic drain();
        int k;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        k = 0;
        while ((outst[0] != 0 || outst[1] != 0) && k < 300) begin
            step();
            k++;
        end
        if (k >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: outstanding %0d/%0d, required 0/0", outst[0], outst[1]);
        end
        repeat (2) step();
    endtask

    initial begin
        int g0, g1, k, p1;
        bit seen1;

        // Reset state
        reset = 1'b1;
        repeat (5) step();
        check_reset_vals("reset");
        req0_valid = 1'b1;
        reset = 1'b0;
        #1 chk("first_cycle_ready", {127'd0, req0_ready}, '0);
        req0_valid = 1'b0;
        step();

        // Single request latency
        req0_data = C_PT; req0_key = C_KEY; req0_valid = 1'b1;
        #1;
        k = 0;
        while (!req0_ready && k < 20) begin step(); #1; k++; end
        chk("single_grant", {127'd0, req0_ready}, 128'd1);
        step();
        req0_valid = 1'b0;
        seen1 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            #1;
            if (rsp1_valid) seen1 = 1'b1;
            if (c == 11) chk("rsp0_valid_t11", {127'd0, rsp0_valid}, '0);
            if (c == 12) begin
                chk("rsp0_valid_t12", {127'd0, rsp0_valid}, 128'd1);
                chk("rsp0_data_vector", rsp0_data, C_CT);
            end
            if (c < 12) step();
        end
        chk("rsp1_quiet", {127'd0, seen1}, '0);
        drain();

        // Alternating grants from reset, back-to-back issue
        do_reset();
        rand_data();
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0;
        while (win_log.size() < 8 && k < 20) begin step(); rand_data(); k++; end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_count", 128'(win_log.size()), 128'd8);
        for (int i = 0; i < 8 && i < win_log.size(); i++)
            chk($sformatf("alt_win%0d", i), 128'(win_log[i]), 128'(i % 2));
        repeat (3) step();
        chk("cs_count", 128'(cs_log.size()), 128'd8);
        if (cs_log.size() == 8) chk("cs_consecutive", 128'(cs_log[7] - cs_log[0]), 128'd7);
        drain();

        // Backpressure on rsp0 must not block requester 1
        g0 = grants[0]; g1 = grants[1];
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (40) begin step(); rand_data(); end
        req1_valid = 1'b0;
        repeat (15) begin step(); rand_data(); end
        chk("bp_req0_grants", 128'(grants[0] - g0), 128'd4);
        chk("bp_req1_progress", {127'd0, (grants[1] - g1) >= 8}, 128'd1);
        chk("bp_req0_blocked", {127'd0, req0_ready}, '0);

        // Pop with grant at credit 0, then at credit 1
        rsp0_ready = 1'b1;
        #1 chk("pop_credit0_nogrant", {127'd0, req0_ready}, '0);
        step(); #1 chk("pop_credit1_grant", {127'd0, req0_ready}, 128'd1);
        step(); #1 chk("credit1_held", {127'd0, req0_ready}, 128'd1);
        drain();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            rsp0_ready = ($urandom_range(0, 2) != 0);
            rsp1_ready = ($urandom_range(0, 2) != 0);
            rand_data();
            step();
        end
        drain();

        // Reset with blocks in flight
        g0 = grants[0] + grants[1];
        req0_valid = 1'b1; req1_valid = 1'b1;
        k = 0;
        while ((grants[0] + grants[1] - g0) < 5 && k < 20) begin step(); rand_data(); k++; end
        chk("inflight_5", 128'(grants[0] + grants[1] - g0), 128'd5);
        req0_valid = 1'b0; req1_valid = 1'b0;
        reset = 1'b1;
        step();
        check_reset_vals("midreset");
        repeat (4) step();
        reset = 1'b0;
        step();
        p1 = pops[1];
        req1_data = rnd128(); req1_key = rnd128(); req1_valid = 1'b1;
        step();
        req1_valid = 1'b0;
        drain();
        chk("post_reset_rsp", 128'(pops[1] - p1), 128'd1);

        // Orphan completion
        chk("err_before", {127'd0, dut.err_orphan_q}, '0);
        inj_data = rnd128(); inj = 1'b1;
        step();
        inj = 1'b0;
        chk("err_orphan", {127'd0, dut.err_orphan_q}, 128'd1);
        for (int i = 0; i < 5; i++) begin
            chk("orphan_no_rsp", {126'd0, rsp1_valid, rsp0_valid}, '0);
            step();
        end

        chk("leftover0", 128'(exp_q[0].size()), '0);
        chk("leftover1", 128'(exp_q[1].size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/aes128_share_arbiter.md
AES128_SHARE_ARBITER -- requirements
Module: aes128_share_arbiter

Interface
REQ-001 Parameter LATENCY, default 10, fixed core cycles from core_start to the matching core_done.
REQ-002 Parameter RESP_DEPTH, default 4, entries per requester response FIFO (power of 2, at least 2).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has a block to encrypt.
REQ-006 reqN_ready  output  1  block accepted on the cycle where reqN_valid and reqN_ready are both high.
REQ-007 reqN_data  input  128  plaintext.
REQ-008 reqN_key  input  128  cipher key.
REQ-009 rspN_valid  output  1  ciphertext available for requester N.
REQ-010 rspN_ready  input  1  requester N consumes the response.
REQ-011 rspN_data  output  128  ciphertext, FIFO head.
REQ-012 core_start  output  1  one-cycle issue strobe to the shared pipelined AES128 core.
REQ-013 core_data, core_key  output  128 each  operands registered on issue.
REQ-014 core_out  input  128  core ciphertext.
REQ-015 core_done  input  1  core result valid, in issue order.

Function
REQ-016 Issue at most one block per cycle; core_start, core_data and core_key are registered.
REQ-017 Requester N is eligible only when reqN_valid=1 and credit_N>0, where credit_N = RESP_DEPTH minus (in-flight blocks for N plus entries held in rsp FIFO N).
REQ-018 Arbitration is round-robin: last_grant register, reset 1, so requester 0 wins the first tie; on a tie the requester not granted last wins; a single eligible requester always wins.
REQ-019 reqN_ready is combinational from eligibility and grant; it is never high for both requesters in the same cycle.
REQ-020 On grant, push the owner ID (1 bit) into a tag shift/FIFO of depth LATENCY+1, and decrement credit_N.
REQ-021 On core_done, pop the tag and write core_out into rsp FIFO[tag] in the same cycle.
REQ-022 core_done with an empty tag FIFO is an error: latch sticky internal flag err_orphan, discard the data, leave state unchanged.
REQ-023 Credit_N increments when rspN_valid and rspN_ready are both high; a simultaneous grant and pop for N leaves credit_N unchanged.
REQ-024 Response FIFOs never overflow by construction (credit); rspN_valid = FIFO N non-empty; first-word fall-through; read and write in the same cycle are both honoured, including at full and at empty.
REQ-025 End-to-end latency, with the response FIFO empty: request handshake at cycle t -> core_start at t+1 -> rspN_valid at t+LATENCY+2.
REQ-026 Order is preserved per requester; results from different requesters may interleave.
REQ-027 Backpressure on rsp0 never blocks requester 1 while credit_1>0.

Reset
REQ-028 After reset: reqN_ready=0 for one cycle, then follows eligibility; core_start=0; core_data=0 and core_key=0; rspN_valid=0; rspN_data=0; tag FIFO empty; credits=RESP_DEPTH; err_orphan=0.
REQ-029 Reset mid-operation discards all in-flight tags and buffered responses; the core is reset on the same reset net, so no stale core_done follows.

Structure
REQ-030 Shared package aes128_pkg holds the AES_BLK_W=128 constant, the default LATENCY, and the requester-ID typedef (1 bit).
REQ-031 One sub-module, aes128_resp_fifo (parameterised depth, 128-bit, FWFT), instantiated twice; the arbiter, credit logic and tag FIFO are inline.

Verification
REQ-032 Bench uses a core model with a LATENCY-deep delay line; reset held 5 cycles.
REQ-033 Single request: req0 data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> rsp0_data=69c4e0d86a7b0430d8cdb78070b4c55a at t+12; rsp1_valid stays 0.
REQ-034 Both requesters valid for 8 cycles, rsp always ready -> grants alternate 0,1,0,1,…; 8 core_start pulses on consecutive cycles; each response is routed to its owner.
REQ-035 rsp0_ready=0, req0 streaming -> exactly RESP_DEPTH=4 grants to req0, then req0_ready=0; req1 continues at full rate; after rsp0_ready=1, one new req0 grant per pop.
REQ-036 Pop and grant in the same cycle at credit_0=0 -> no grant that cycle; at credit_0=1 the grant proceeds and credit_0 remains 1.
REQ-037 Reset asserted with 5 blocks in flight -> next cycle all outputs at reset values; post-reset request completes correctly.
REQ-038 Injected core_done with no issue outstanding -> err_orphan=1; no rsp_valid asserted.
